zrl_run_encoder: RTL and testbench



---
 rtl/zrl_pkg.sv | 33 +++
 rtl/zrl_pack.sv | 43 ++++
 rtl/zrl_run_encoder.sv | 157 +++++++++++++++
 tb/tb_zrl_run_encoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zrl_pkg.sv
// Shared types and sizing helpers for the zero-run-length encoder.
// Code sizes are in bits; OUT_W is the widest code including the header.
package zrl_pkg;

    localparam logic [1:0] SOP_HDR_DEF = 2'b01;

    typedef enum logic [2:0] {
        A_NONE,
        A_HOLD,
        A_FLUSH,
        A_RUN,
        A_NZ,
        A_SPLIT
    } act_e;

    function automatic int out_w(input int sym_w, input int nsym);
        return 3 + nsym + nsym * sym_w;
    endfunction

    function automatic int size_w(input int sym_w, input int nsym);
        return $clog2(out_w(sym_w, nsym) + 1);
    endfunction

    function automatic int nonzero_size(input int sym_w, input int nsym,
                                        input int pop);
        return 1 + nsym + pop * sym_w;
    endfunction

    function automatic int run_size(input int run_w);
        return 1 + run_w;
    endfunction

endpackage

// File: rtl/zrl_pack.sv
// Builds the nonzero-beat code: optional header, flag, mask and
// the nonzero symbols compacted MSB-first in descending index order.
module zrl_pack
    import zrl_pkg::*;
#(
    parameter int         SYM_W   = 16,
    parameter int         NSYM    = 4,
    parameter logic [1:0] SOP_HDR = SOP_HDR_DEF,
    localparam int        OUT_W   = out_w(SYM_W, NSYM),
    localparam int        SZ_W    = size_w(SYM_W, NSYM)
) (
    input  logic [NSYM*SYM_W-1:0] i_data,
    input  logic                  i_sop,
    output logic [NSYM-1:0]       o_mask,
    output logic [OUT_W-1:0]      o_code,
    output logic [SZ_W-1:0]       o_size
);

    localparam int PC_W = $clog2(NSYM + 1);

    logic [NSYM*SYM_W-1:0] w_pk;
    logic [OUT_W-3:0]      w_body;
    logic [PC_W-1:0]       w_pop;

    always_comb begin
        w_pk  = '0;
        w_pop = '0;
        for (int k = 0; k < NSYM; k++) begin
            o_mask[k] = |i_data[k*SYM_W +: SYM_W];
            w_pop     = w_pop + PC_W'(o_mask[k]);
            // shifting down before inserting leaves the highest index on top
            if (o_mask[k]) begin
                w_pk = w_pk >> SYM_W;
                w_pk[NSYM*SYM_W-1 -: SYM_W] = i_data[k*SYM_W +: SYM_W];
            end
        end
        w_body = {1'b1, o_mask, w_pk};
        o_code = i_sop ? {SOP_HDR, w_body} : {w_body, 2'b00};
        o_size = SZ_W'(nonzero_size(SYM_W, NSYM, int'(w_pop)))
               + (i_sop ? SZ_W'(2) : SZ_W'(0));
    end

endmodule

// File: rtl/zrl_run_encoder.sv
// Zero-run-length encoder: merges all-zero beats into run codes and
// emits mask codes for other beats, with a one-entry hold for splits.
module zrl_run_encoder
    import zrl_pkg::*;
#(
    parameter int         SYM_W   = 16,
    parameter int         NSYM    = 4,
    parameter int         RUN_W   = 4,
    parameter logic [1:0] SOP_HDR = SOP_HDR_DEF,
    localparam int        OUT_W   = out_w(SYM_W, NSYM),
    localparam int        SZ_W    = size_w(SYM_W, NSYM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSYM*SYM_W-1:0] data_i,
    input  logic                  valid_i,
    input  logic                  sop_i,
    input  logic                  eop_i,
    output logic                  ready_o,
    output logic [OUT_W-1:0]      data_o,
    output logic [SZ_W-1:0]       size_o,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    logic [RUN_W-1:0] r_run_cnt;
    logic             r_run_sop;
    logic             r_hold_valid;
    logic [OUT_W-1:0] r_hold_code;
    logic [SZ_W-1:0]  r_hold_size;
    logic             r_hold_eop;

    logic             w_load;
    logic             w_acc;
    logic             w_run_idle;
    logic             w_run_sop;
    logic [RUN_W:0]   w_n;
    logic [NSYM-1:0]  w_mask;
    logic [OUT_W-1:0] w_code;
    logic [SZ_W-1:0]  w_size;
    act_e             w_act;

    function automatic logic [OUT_W-1:0] run_code(
        input logic [RUN_W-1:0] f,
        input logic             s
    );
        logic [OUT_W-1:0] c;
        c = '0;
        if (s) c[OUT_W-1 -: RUN_W+3] = {SOP_HDR, 1'b0, f};
        else   c[OUT_W-1 -: RUN_W+1] = {1'b0, f};
        return c;
    endfunction

    function automatic logic [SZ_W-1:0] run_len(input logic s);
        return SZ_W'(run_size(RUN_W)) + (s ? SZ_W'(2) : SZ_W'(0));
    endfunction

    assign w_load     = !valid_o || ready_i;
    assign ready_o    = w_load && !r_hold_valid;
    assign w_acc      = valid_i && ready_o;
    assign w_run_idle = (r_run_cnt == '0);
    assign w_run_sop  = w_run_idle ? sop_i : r_run_sop;
    assign w_n        = {1'b0, r_run_cnt} + (RUN_W+1)'(1);

    // a beat arriving mid-run never carries the packet header
    zrl_pack #(
        .SYM_W   (SYM_W),
        .NSYM    (NSYM),
        .SOP_HDR (SOP_HDR)
    ) u_pack (
        .i_data (data_i),
        .i_sop  (sop_i && w_run_idle),
        .o_mask (w_mask),
        .o_code (w_code),
        .o_size (w_size)
    );

    always_comb begin
        w_act = A_NONE;
        if (r_hold_valid) begin
            w_act = A_HOLD;
        end else if (w_acc) begin
            if (w_mask == '0)
                w_act = (w_n[RUN_W] || eop_i) ? A_FLUSH : A_RUN;
            else if (w_run_idle)
                w_act = A_NZ;
            else
                w_act = A_SPLIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o       <= '0;
            size_o       <= '0;
            sop_o        <= 1'b0;
            eop_o        <= 1'b0;
            valid_o      <= 1'b0;
            r_run_cnt    <= '0;
            r_run_sop    <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_code  <= '0;
            r_hold_size  <= '0;
            r_hold_eop   <= 1'b0;
        end else if (w_load) begin
            unique case (w_act)
                A_HOLD: begin
                    data_o       <= r_hold_code;
                    size_o       <= r_hold_size;
                    sop_o        <= 1'b0;
                    eop_o        <= r_hold_eop;
                    valid_o      <= 1'b1;
                    r_hold_valid <= 1'b0;
                end
                A_FLUSH: begin
                    data_o    <= run_code(r_run_cnt, w_run_sop);
                    size_o    <= run_len(w_run_sop);
                    sop_o     <= w_run_sop;
                    eop_o     <= eop_i;
                    valid_o   <= 1'b1;
                    r_run_cnt <= '0;
                    r_run_sop <= w_run_sop;
                end
                A_RUN: begin
                    r_run_cnt <= w_n[RUN_W-1:0];
                    r_run_sop <= w_run_sop;
                    valid_o   <= 1'b0;
                end
                A_NZ: begin
                    data_o  <= w_code;
                    size_o  <= w_size;
                    sop_o   <= sop_i;
                    eop_o   <= eop_i;
                    valid_o <= 1'b1;
                end
                A_SPLIT: begin
                    data_o       <= run_code(r_run_cnt - 1'b1, r_run_sop);
                    size_o       <= run_len(r_run_sop);
                    sop_o        <= r_run_sop;
                    eop_o        <= 1'b0;
                    valid_o      <= 1'b1;
                    r_hold_valid <= 1'b1;
                    r_hold_code  <= w_code;
                    r_hold_size  <= w_size;
                    r_hold_eop   <= eop_i;
                    r_run_cnt    <= '0;
                end
                default: begin
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zrl_run_encoder.sv
// Scoreboard bench for zrl_run_encoder at the default parameters.
// A transaction-level model predicts codes as beats are accepted.
module tb_zrl_run_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] data_i;
    logic        valid_i, sop_i, eop_i, ready_o;
    logic [70:0] data_o;
    logic [6:0]  size_o;
    logic        sop_o, eop_o, valid_o, ready_i;

    zrl_run_encoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .sop_i   (sop_i),
        .eop_i   (eop_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .size_o  (size_o),
        .sop_o   (sop_o),
        .eop_o   (eop_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [70:0] code;
        logic [6:0]  size;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_run = 0;
    bit   m_rsop = 1'b0;
    bit   done = 1'b0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t enc_nz(input logic [63:0] d, input bit s,
                                    input bit e);
        logic [70:0] c;
        logic [15:0] sym;
        int len;
        c = '0;
        len = 0;
        if (s) begin c[70] = 1'b0; c[69] = 1'b1; len = 2; end
        c[70-len] = 1'b1; len++;
        for (int k = 3; k >= 0; k--) begin
            c[70-len] = (d[k*16 +: 16] != 16'h0); len++;
        end
        for (int k = 3; k >= 0; k--) begin
            sym = d[k*16 +: 16];
            if (sym != 16'h0)
                for (int b = 15; b >= 0; b--) begin
                    c[70-len] = sym[b]; len++;
                end
        end
        return '{code: c, size: 7'(len), sop: s, eop: e};
    endfunction

    function automatic exp_t enc_run(input int n, input bit s, input bit e);
        logic [70:0] c;
        logic [3:0]  f;
        int len;
        c = '0;
        len = 0;
        f = 4'(n - 1);
        if (s) begin c[70] = 1'b0; c[69] = 1'b1; len = 2; end
        c[70-len] = 1'b0; len++;
        for (int b = 3; b >= 0; b--) begin
            c[70-len] = f[b]; len++;
        end
        return '{code: c, size: 7'(len), sop: s, eop: e};
    endfunction

    task automatic model_beat(input logic [63:0] d, input bit s, input bit e);
        int n;
        if (d == 64'h0) begin
            if (m_run == 0) m_rsop = s;
            n = m_run + 1;
            if (n == 16 || e) begin
                q.push_back(enc_run(n, m_rsop, e));
                m_run = 0;
            end else begin
                m_run = n;
            end
        end else if (m_run == 0) begin
            q.push_back(enc_nz(d, s, e));
        end else begin
            q.push_back(enc_run(m_run, m_rsop, 1'b0));
            q.push_back(enc_nz(d, 1'b0, e));
            m_run = 0;
        end
    endtask

    // called at posedge+1, returns at posedge+1 after the accepting edge
    task automatic send(input logic [63:0] d, input bit s, input bit e);
        int t = 0;
        data_i  = d;
        sop_i   = s;
        eop_i   = e;
        valid_i = 1'b1;
        @(negedge clk);
        while (!ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready_o) begin
            check("accept_timeout", ready_o, 1);
        end else begin
            model_beat(d, s, e);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (rst_n && valid_o && ready_i) begin
            if (q.size() == 0) begin
                check("spurious_valid", valid_o, 0);
            end else begin
                x = q.pop_front();
                check("data", data_o, x.code);
                check("size", size_o, x.size);
                check("sop", sop_o, x.sop);
                check("eop", eop_o, x.eop);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t st;
        logic [63:0] d;
        int len;

        rst_n = 1'b0; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
        data_i = '0; ready_i = 1'b1;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_size", size_o, 0);
        check("rst_sop", sop_o, 0);
        check("rst_eop", eop_o, 0);
        check("rst_ready", ready_o, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(64'h0000_1234_0000_ABCD, 1, 1);
        idle(2);

        send(64'h0, 1, 0);
        send(64'h0, 0, 0);
        send(64'h0, 0, 1);
        idle(2);

        for (int i = 0; i < 16; i++) send(64'h0, 0, 0);
        send(64'h0, 0, 0);
        @(negedge clk);
        check("run17_quiet", valid_o, 0);
        @(posedge clk);
        #1;
        send(64'h0, 0, 1);
        idle(2);

        send(64'h0, 1, 0);
        send(64'h0, 0, 0);
        send(64'hFFFF_0000_0000_0000, 0, 1);
        @(negedge clk);
        check("bubble_ready", ready_o, 0);
        @(posedge clk);
        #1;
        idle(2);

        st = enc_nz(64'h0000_0000_0000_0055, 1, 1);
        send(64'h0000_0000_0000_0055, 1, 1);
        ready_i = 1'b0;
        fork
            send(64'h0077_0000_0000_0000, 1, 1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_valid", valid_o, 1);
                    check("stall_ready", ready_o, 0);
                    check("stall_size", size_o, st.size);
                    check("stall_data", data_o, st.code);
                end
                @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join
        idle(2);

        send(64'h0, 1, 0);
        send(64'h0, 0, 0);
        #3;
        rst_n = 1'b0;
        m_run = 0;
        #1;
        check("midrst_valid", valid_o, 0);
        check("midrst_size", size_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(64'h0000_0000_0009_0000, 1, 1);
        idle(2);

        send(64'h1111_2222_3333_4444, 0, 0);
        send(64'h1111_0000_0000_0001, 0, 0);
        send(64'h0000_00A0_0B00_0000, 0, 0);
        send(64'h8000_8000_8000_8000, 0, 1);
        idle(2);

        fork
            begin
                for (int p = 0; p < 12; p++) begin
                    len = $urandom_range(1, 20);
                    for (int i = 0; i < len; i++) begin
                        d = '0;
                        if ($urandom_range(0, 1) == 1)
                            for (int k = 0; k < 4; k++)
                                if ($urandom_range(0, 1) == 1)
                                    d[k*16 +: 16] = 16'($urandom_range(1, 65535));
                        send(d, i == 0, i == len - 1);
                    end
                end
                done = 1'b1;
            end
            begin
                for (int c = 0; c < 5000 && !done; c++) begin
                    @(posedge clk);
                    #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
                ready_i = 1'b1;
            end
        join
        ready_i = 1'b1;
        idle(10);
        check("drain_queue", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
